// File: rtl/calc_defs.sv
// Shared keypad and opcode definitions for the calculator command path.
package calc_defs;

    localparam int unsigned KEY_W   = 5;
    localparam int unsigned FUNCT_W = 3;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [KEY_W-1:0] KEY_PLUS      = 5'd10;
    localparam logic [KEY_W-1:0] KEY_MINUS     = 5'd11;
    localparam logic [KEY_W-1:0] KEY_EQUALS    = 5'd12;
    localparam logic [KEY_W-1:0] KEY_CLEAR     = 5'd13;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD      = 3'b100;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB      = 3'b101;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD_PREV = 3'b000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB_PREV = 3'b001;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2
    } enc_state_e;

    // Bit 2 selects two-operand vs accumulate-on-previous, bit 0 selects subtract.
    function automatic logic [FUNCT_W-1:0] funct_pick(input logic to_prev, input logic minus);
        return {~to_prev, 1'b0, minus};
    endfunction

endpackage

// File: rtl/calc_digit_accum.sv
// Decimal operand accumulator: value = value*10 + digit, capped at MAX_DIGITS digits.
module calc_digit_accum
    import calc_defs::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_digit_valid,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [WIDTH-1:0]   o_value,
    output logic [WIDTH-1:0]   o_value_nxt_c,
    output logic               o_has_digits_c
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    logic [WIDTH-1:0] r_value;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_value_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_room;

    assign w_room = r_count < CNT_W'(MAX_DIGITS);

    always_comb begin
        w_value_nxt = r_value;
        w_count_nxt = r_count;
        if (i_clear) begin
            w_value_nxt = '0;
            w_count_nxt = '0;
        end else if (i_digit_valid && w_room) begin
            w_value_nxt = WIDTH'(r_value * WIDTH'(10)) + WIDTH'(i_digit);
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_value <= w_value_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign o_value        = r_value;
    assign o_value_nxt_c  = w_value_nxt;
    assign o_has_digits_c = r_count != '0;

endmodule

// File: rtl/calc_cmd_encoder.sv
// Turns keypad presses into (funct, operand_a, operand_b) commands with a valid/ready handshake.
module calc_cmd_encoder
    import calc_defs::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key_code,
    output logic               key_ready,
    output logic [FUNCT_W-1:0] funct,
    output logic [WIDTH-1:0]   operand_a,
    output logic [WIDTH-1:0]   operand_b,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [WIDTH-1:0]   display_value
);

    enc_state_e         r_state, w_state_nxt;
    logic [FUNCT_W-1:0] r_funct, w_funct_nxt;
    logic               r_prev_valid, w_prev_nxt;
    logic               r_cmd_valid, r_key_ready;
    logic [WIDTH-1:0]   r_display;
    logic [WIDTH-1:0]   w_a_nxt, w_b_nxt;
    logic               w_clr_a, w_clr_b, w_dig_a, w_dig_b;
    logic               w_a_has, w_b_has;
    logic               w_key_acc, w_is_digit, w_is_op, w_minus;
    logic [DIGIT_W-1:0] w_digit;

    assign w_key_acc  = key_valid & r_key_ready;
    assign w_is_digit = key_code <= KEY_DIGIT_MAX;
    assign w_is_op    = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
    assign w_minus    = key_code == KEY_MINUS;
    assign w_digit    = key_code[DIGIT_W-1:0];

    calc_digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .reset(reset), .i_clear(w_clr_a), .i_digit_valid(w_dig_a),
        .i_digit(w_digit), .o_value(operand_a), .o_value_nxt_c(w_a_nxt),
        .o_has_digits_c(w_a_has)
    );

    calc_digit_accum #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .reset(reset), .i_clear(w_clr_b), .i_digit_valid(w_dig_b),
        .i_digit(w_digit), .o_value(operand_b), .o_value_nxt_c(w_b_nxt),
        .o_has_digits_c(w_b_has)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_funct_nxt = r_funct;
        w_prev_nxt  = r_prev_valid;
        w_clr_a     = 1'b0;
        w_clr_b     = 1'b0;
        w_dig_a     = 1'b0;
        w_dig_b     = 1'b0;
        case (r_state)
            S_A, S_B: begin
                if (w_key_acc) begin
                    if (key_code == KEY_CLEAR) begin
                        w_state_nxt = S_A;
                        w_funct_nxt = '0;
                        w_prev_nxt  = 1'b0;
                        w_clr_a     = 1'b1;
                        w_clr_b     = 1'b1;
                    end else if (w_is_digit) begin
                        w_dig_a = (r_state == S_A);
                        w_dig_b = (r_state == S_B);
                    end else if (w_is_op) begin
                        if (r_state == S_A) begin
                            if (w_a_has) begin
                                w_funct_nxt = funct_pick(1'b0, w_minus);
                                w_state_nxt = S_B;
                            end else if (r_prev_valid) begin
                                w_funct_nxt = funct_pick(1'b1, w_minus);
                                w_clr_a     = 1'b1;
                                w_state_nxt = S_B;
                            end
                        end else if (!w_b_has) begin
                            // Operator change before any B digit keeps the Prev class.
                            w_funct_nxt = funct_pick(~r_funct[FUNCT_W-1], w_minus);
                        end
                    end else if ((key_code == KEY_EQUALS) && (r_state == S_B) && w_b_has) begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = S_A;
                    w_prev_nxt  = 1'b1;
                    w_clr_a     = 1'b1;
                    w_clr_b     = 1'b1;
                end
            end
            default: w_state_nxt = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_A;
            r_funct      <= '0;
            r_prev_valid <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_key_ready  <= 1'b1;
            r_display    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_funct      <= w_funct_nxt;
            r_prev_valid <= w_prev_nxt;
            r_cmd_valid  <= (w_state_nxt == S_ISSUE);
            r_key_ready  <= (w_state_nxt != S_ISSUE);
            r_display    <= (w_state_nxt == S_A) ? w_a_nxt : w_b_nxt;
        end
    end

    assign key_ready     = r_key_ready;
    assign funct         = r_funct;
    assign cmd_valid     = r_cmd_valid;
    assign display_value = r_display;

endmodule

// File: tb/tb_calc_cmd_encoder.sv
// Directed bench for calc_cmd_encoder with a key-event reference model checked every cycle.
module tb_calc_cmd_encoder;
    import calc_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        key_valid, cmd_ready;
    logic [4:0]  key_code;
    logic        key_ready, cmd_valid;
    logic [2:0]  funct;
    logic [15:0] operand_a, operand_b, display_value;

    always #5 clk = ~clk;

    calc_cmd_encoder #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .funct(funct), .operand_a(operand_a),
        .operand_b(operand_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .display_value(display_value)
    );

    int checks = 0;
    int errors = 0;
    int dut_xfers = 0;
    int mdl_xfers = 0;

    always @(posedge clk) if (cmd_valid && cmd_ready) dut_xfers <= dut_xfers + 1;

    // Model: 0 = entering A, 1 = entering B, 2 = command pending
    int m_st, m_a, m_b, m_na, m_nb, m_funct;
    bit m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_funct = 0; m_prev = 0;
    endtask

    task automatic model_step();
        int k;
        bit minus;
        k = int'(key_code);
        minus = (k == 11);
        if (reset) begin
            model_reset();
        end else if (m_st == 2) begin
            if (cmd_ready) begin
                mdl_xfers++;
                m_st = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_prev = 1;
            end
        end else if (key_valid) begin
            if (k <= 9) begin
                if (m_st == 0 && m_na < 4) begin m_a = m_a * 10 + k; m_na++; end
                if (m_st == 1 && m_nb < 4) begin m_b = m_b * 10 + k; m_nb++; end
            end else if (k == 13) begin
                model_reset();
            end else if (k == 10 || k == 11) begin
                if (m_st == 0) begin
                    if (m_na > 0) begin
                        m_funct = minus ? 5 : 4; m_st = 1;
                    end else if (m_prev) begin
                        m_funct = minus ? 1 : 0; m_a = 0; m_st = 1;
                    end
                end else if (m_nb == 0) begin
                    m_funct = (m_funct & 4) | (minus ? 1 : 0);
                end
            end else if (k == 12 && m_st == 1 && m_nb > 0) begin
                m_st = 2;
            end
        end
    endtask

    task automatic compare();
        check("cmd_valid", 32'(cmd_valid), 32'(m_st == 2));
        check("key_ready", 32'(key_ready), 32'(m_st != 2));
        check("display", 32'(display_value), 32'((m_st == 0) ? m_a : m_b));
        check("xfer_count", 32'(dut_xfers), 32'(mdl_xfers));
        if (m_st == 2) begin
            check("cmd_funct", 32'(funct), 32'(m_funct));
            check("cmd_a", 32'(operand_a), 32'(m_a));
            check("cmd_b", 32'(operand_b), 32'(m_b));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 5'd0;
    endtask

    task automatic expect_cmd(input string tag, input int f, input int a, input int b);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        check({tag, "_funct"}, 32'(funct), 32'(f));
        check({tag, "_a"}, 32'(operand_a), 32'(a));
        check({tag, "_b"}, 32'(operand_b), 32'(b));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_funct"}, 32'(funct), 32'd0);
        check({tag, "_a"}, 32'(operand_a), 32'd0);
        check({tag, "_b"}, 32'(operand_b), 32'd0);
        check({tag, "_disp"}, 32'(display_value), 32'd0);
        check({tag, "_ready"}, 32'(key_ready), 32'd1);
    endtask

    initial begin
        key_valid = 1'b0;
        key_code  = 5'd0;
        cmd_ready = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1 expect_idle("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 12 + 3 with datapath already ready: single-cycle command
        cmd_ready = 1'b1;
        press(5'd1); press(5'd2); press(KEY_PLUS); press(5'd3); press(KEY_EQUALS);
        expect_cmd("add12_3", 4, 12, 3);
        tick();
        check("add12_3_drop", 32'(cmd_valid), 32'd0);
        check("add12_3_xfers", 32'(dut_xfers), 32'd1);

        // Subtract from previous result
        press(KEY_MINUS); press(5'd4); press(KEY_EQUALS);
        expect_cmd("subprev4", 1, 0, 4);
        tick();
        check("subprev4_xfers", 32'(dut_xfers), 32'd2);

        // 5 - 7 held while the datapath stalls
        cmd_ready = 1'b0;
        press(5'd5); press(KEY_MINUS); press(5'd7); press(KEY_EQUALS);
        expect_cmd("sub5_7", 5, 5, 7);
        repeat (5) tick();
        expect_cmd("sub5_7_held", 5, 5, 7);
        check("sub5_7_noxfer", 32'(dut_xfers), 32'd2);
        cmd_ready = 1'b1;
        tick();
        check("sub5_7_drop", 32'(cmd_valid), 32'd0);
        check("sub5_7_xfers", 32'(dut_xfers), 32'd3);
        check("sub5_7_disp", 32'(display_value), 32'd0);

        // Fifth digit dropped; CLEAR kills prev_valid so the PLUS is ignored
        press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
        check("max_digits", 32'(display_value), 32'd1234);
        press(KEY_CLEAR);
        check("clear_disp", 32'(display_value), 32'd0);
        press(KEY_PLUS);
        press(5'd7); press(KEY_PLUS); press(5'd2); press(KEY_EQUALS);
        expect_cmd("after_clear", 4, 7, 2);
        tick();
        check("after_clear_xfers", 32'(dut_xfers), 32'd4);

        // Operator replaced before B digits; operator after B digit ignored
        press(5'd9); press(KEY_PLUS); press(KEY_MINUS); press(5'd6); press(KEY_PLUS);
        press(KEY_EQUALS);
        expect_cmd("replace_op", 5, 9, 6);
        tick();
        check("replace_op_xfers", 32'(dut_xfers), 32'd5);

        // Async reset during a stalled command aborts it
        cmd_ready = 1'b0;
        press(5'd1); press(KEY_PLUS); press(5'd2); press(KEY_EQUALS);
        expect_cmd("abort_pre", 4, 1, 2);
        tick();
        #2 reset = 1'b1;
        #1 model_reset();
        expect_idle("abort_now");
        cmd_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("abort_xfers", 32'(dut_xfers), 32'd5);

        // Fresh after reset: PLUS with no digits and no previous result is ignored
        press(KEY_PLUS); press(5'd3);
        check("post_reset_disp", 32'(display_value), 32'd3);
        check("post_reset_opa", 32'(operand_a), 32'd3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
